// File: rtl/multi_slow_clock.sv
// -----------------------------------------------------------------------------
// multi_slow_clock
//
// Multi-channel programmable slow-clock generator. Each channel divides clkin
// down to a 50% duty square wave (clkout) and emits a one-cycle strobe (tick)
// on every clkout toggle. Half period of a channel is div_reg+1 clkin cycles.
// The divide value of each channel can be rewritten at run time, each channel
// has its own count enable, and a shared sync strobe restarts every channel
// in phase.
//
// Parameters:
//   CNT_W       width of each channel's down-counter and divide register
//   NUM_CH      number of independent output channels (1..16)
//   CH_W        width of load_ch (2**CH_W >= NUM_CH)
//   DEFAULT_DIV divide value loaded into every channel on reset
//
// Ports:
//   clkin     in   1       system clock, rising edge only
//   rst       in   1       synchronous active-high reset
//   en        in   NUM_CH  per-channel count enable
//   sync      in   1       one-cycle strobe, restarts all channels at clkout=0
//   load      in   1       divide register write strobe
//   load_ch   in   CH_W    channel written by load (out-of-range is ignored)
//   load_val  in   CNT_W   new divide value D (half period = D+1 cycles)
//   clkout    out  NUM_CH  divided clock per channel
//   tick      out  NUM_CH  registered pulse coincident with each new clkout level
// -----------------------------------------------------------------------------
module multi_slow_clock #(
    parameter int CNT_W       = 25,
    parameter int NUM_CH      = 2,
    parameter int CH_W        = 1,
    parameter int DEFAULT_DIV = 9999999
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              load,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [CNT_W-1:0]  load_val,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_reg;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_next;
        logic             wr;
        logic             clk_q;
        logic             tick_q;

        // An index at or above NUM_CH matches no channel, so such a write
        // is dropped without touching any state.
        assign wr       = load && (int'(load_ch) == i);
        assign div_next = wr ? load_val : div_reg;

        always_ff @(posedge clkin) begin
            if (rst) begin
                div_reg <= DIV_RST;
                cnt     <= DIV_RST;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                div_reg <= div_next;
                if (sync) begin
                    // Restart from the freshly written divide value so a
                    // load and sync in the same cycle take effect together.
                    cnt    <= div_next;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (en[i]) begin
                    if (cnt == '0) begin
                        // Reload uses the value in force before any
                        // same-cycle load; the load lands at the next reload.
                        cnt    <= div_reg;
                        clk_q  <= ~clk_q;
                        tick_q <= 1'b1;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        tick_q <= 1'b0;
                    end
                end else begin
                    tick_q <= 1'b0;
                end
            end
        end

        assign clkout[i] = clk_q;
        assign tick[i]   = tick_q;
    end

endmodule
